// File: rtl/color_pkg.sv
// Shared colour-path types: scheduler state encoding and the packed RGB triple
// used by the scheduler, the WS2812 driver and the CLS381 read engine.
package color_pkg;

  localparam int RGB_W = 8;

  typedef struct packed {
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } rgb_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    START,
    WAIT_DATA,
    ACCUM,
    PUSH
  } sched_state_t;

endpackage

// File: rtl/rgb_accumulator.sv
// Three per-channel accumulators sized so a full burst of 2^AVG_LOG2 samples
// cannot overflow; avg is the truncating burst mean.
module rgb_accumulator
  import color_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic add,
  input  rgb_t sample,
  output rgb_t avg
);

  localparam int ACC_W = RGB_W + AVG_LOG2;

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_g;
  logic [ACC_W-1:0] acc_b;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_r <= '0;
      acc_g <= '0;
      acc_b <= '0;
    end else if (add) begin
      acc_r <= acc_r + ACC_W'(sample.r);
      acc_g <= acc_g + ACC_W'(sample.g);
      acc_b <= acc_b + ACC_W'(sample.b);
    end
  end

  always_comb begin
    avg.r = RGB_W'(acc_r >> AVG_LOG2);
    avg.g = RGB_W'(acc_g >> AVG_LOG2);
    avg.b = RGB_W'(acc_b >> AVG_LOG2);
  end

endmodule

// File: rtl/color_read_scheduler.sv
// Periodic CLS381 burst-read scheduler: averages 2^AVG_LOG2 reads per tick and
// hands the result to the WS2812 driver; reports timeout, sensor error, overrun.
module color_read_scheduler
  import color_pkg::*;
#(
  parameter int PERIOD_CYC  = 5_000_000,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             enable,
  output logic             sensor_start,
  input  logic             sensor_done,
  input  logic             sensor_err,
  input  logic [RGB_W-1:0] sens_r,
  input  logic [RGB_W-1:0] sens_g,
  input  logic [RGB_W-1:0] sens_b,
  output logic             led_valid,
  input  logic             led_ready,
  output logic [RGB_W-1:0] led_r,
  output logic [RGB_W-1:0] led_g,
  output logic [RGB_W-1:0] led_b,
  output logic             busy,
  output logic             timeout_err,
  output logic             sensor_fail,
  output logic             overrun
);

  localparam int TICK_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int IDX_W  = AVG_LOG2 + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PERIOD_CYC - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0]  BURST_LEN = IDX_W'(1 << AVG_LOG2);

  sched_state_t      state;
  sched_state_t      state_nx;
  logic [TICK_W-1:0] tick_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [IDX_W-1:0]  sample_idx;
  logic              tick;
  logic              acc_clear;
  logic              acc_add;
  logic              load_led;
  logic              set_timeout;
  logic              set_fail;
  logic              set_overrun;
  rgb_t              sample;
  rgb_t              avg;
  rgb_t              led_q;

  assign tick   = (state != IDLE) && (tick_cnt == TICK_LAST);
  assign sample = {sens_r, sens_g, sens_b};

  rgb_accumulator #(
    .AVG_LOG2(AVG_LOG2)
  ) u_acc (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .clear (acc_clear),
    .add   (acc_add),
    .sample(sample),
    .avg   (avg)
  );

  always_comb begin
    state_nx    = state;
    acc_clear   = 1'b0;
    acc_add     = 1'b0;
    load_led    = 1'b0;
    set_timeout = 1'b0;
    set_fail    = 1'b0;
    // Ticks during a burst or push are flagged and dropped, never queued.
    set_overrun = tick && (state inside {START, WAIT_DATA, ACCUM, PUSH});
    unique case (state)
      IDLE: begin
        if (enable) state_nx = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!enable) begin
          state_nx = IDLE;
        end else if (tick) begin
          state_nx  = START;
          acc_clear = 1'b1;
        end
      end
      START: state_nx = WAIT_DATA;
      WAIT_DATA: begin
        if (sensor_err) begin
          set_fail = 1'b1;
          state_nx = WAIT_TICK;
        end else if (sensor_done) begin
          acc_add  = 1'b1;
          state_nx = ACCUM;
        end else if (to_cnt == TO_LAST) begin
          set_timeout = 1'b1;
          state_nx    = WAIT_TICK;
        end
      end
      ACCUM: begin
        // avg already includes the sample added on entry to ACCUM.
        if (sample_idx + 1'b1 == BURST_LEN) begin
          load_led = 1'b1;
          state_nx = PUSH;
        end else begin
          state_nx = START;
        end
      end
      PUSH: begin
        if (led_ready) state_nx = WAIT_TICK;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      to_cnt      <= '0;
      sample_idx  <= '0;
      led_q       <= '0;
      timeout_err <= 1'b0;
      sensor_fail <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state <= state_nx;

      if (state == IDLE || tick) tick_cnt <= '0;
      else                       tick_cnt <= tick_cnt + 1'b1;

      if (state == IDLE || state == START) to_cnt <= '0;
      else if (state == WAIT_DATA)         to_cnt <= to_cnt + 1'b1;

      if (state == IDLE || acc_clear) sample_idx <= '0;
      else if (state == ACCUM)        sample_idx <= sample_idx + 1'b1;

      if (load_led)    led_q       <= avg;
      if (set_timeout) timeout_err <= 1'b1;
      if (set_fail)    sensor_fail <= 1'b1;
      if (set_overrun) overrun     <= 1'b1;
    end
  end

  assign sensor_start = (state == START);
  assign led_valid    = (state == PUSH);
  assign busy         = !(state inside {IDLE, WAIT_TICK});
  assign led_r        = led_q.r;
  assign led_g        = led_q.g;
  assign led_b        = led_q.b;

endmodule

// File: doc/color_read_scheduler.md
# color_read_scheduler

Periodic scheduler between the CLS381 colour-sensor read engine and the WS2812 LED driver. On every sample tick it issues a burst of 2^AVG_LOG2 sensor reads, accumulates and averages the R/G/B results, and presents the averaged colour to the LED driver on a valid/ready handshake. It also owns read timeout, sensor-error and overrun reporting for the colour-recognition path.

## Interface
- PERIOD_CYC, 5_000_000 — sample-tick period in sys_clk cycles (100 ms at 50 MHz); must be ≥ 2.
- AVG_LOG2, 2 — log2 of reads averaged per burst (0..4).
- TIMEOUT_CYC, 1_000_000 — maximum cycles to wait for sensor_done after sensor_start.

Ports:
- sys_clk  in  1  system clock; only clock.
- sys_rst  in  1  synchronous, active-high reset.
- enable  in  1  run enable.
- sensor_start  out  1  one-cycle pulse; starts one sensor read.
- sensor_done  in  1  one-cycle pulse; sens_r/g/b valid this cycle.
- sensor_err  in  1  one-cycle pulse; the read failed (NACK etc.).
- sens_r, sens_g, sens_b  in  8 each  raw sensor colour.
- led_valid  out  1  averaged colour available.
- led_ready  in  1  LED driver accepts.
- led_r, led_g, led_b  out  8 each  averaged colour.
- busy  out  1  high in every state except IDLE and WAIT_TICK.
- timeout_err  out  1  sticky; set on read timeout.
- sensor_fail  out  1  sticky; set on sensor_err.
- overrun  out  1  sticky; set when a tick arrives while a burst or push is still in progress.

## Operation
- States: IDLE, WAIT_TICK, START, WAIT_DATA, ACCUM, PUSH.
- IDLE: counters cleared. Go to WAIT_TICK when enable = 1.
- Tick counter: counts 0..PERIOD_CYC-1 while the FSM is outside IDLE and wraps. A tick is the cycle where count = PERIOD_CYC-1.
- WAIT_TICK:
  - enable = 0 → IDLE.
  - tick → START, with accumulators and sample index cleared.
- START: sensor_start = 1 for exactly one cycle → WAIT_DATA, with the timeout counter cleared.
- WAIT_DATA:
  - sensor_done → ACCUM, capturing sens_* into the accumulators.
  - sensor_err, or sensor_done and sensor_err in the same cycle → abort.
  - Timeout counter reaches TIMEOUT_CYC-1 → abort.
  - Abort: set sensor_fail (sensor_err) or timeout_err (timeout), discard the partial burst, go to WAIT_TICK; no LED push.
- ACCUM: increment the sample index.
  - Index reaches 2^AVG_LOG2 → PUSH.
  - Otherwise → START.
- PUSH:
  - led_r/g/b = acc >> AVG_LOG2, truncating.
  - led_valid held high with stable data until led_ready.
  - The handshake cycle (valid & ready) → WAIT_TICK.
- Accumulators are 8+AVG_LOG2 bits each and cannot overflow.
- enable is sampled only in WAIT_TICK. Deasserting it mid-burst lets the burst and its push complete.
- A tick in START, WAIT_DATA, ACCUM or PUSH sets overrun and is dropped; it is not queued.
- Sticky flags clear only on sys_rst.

## Timing
- Reset values, all registered outputs: sensor_start=0, led_valid=0, led_r/g/b=0, busy=0, timeout_err=0, sensor_fail=0, overrun=0. State = IDLE. Counters = 0.
- Reset asserted mid-burst or mid-push takes effect the next edge. The read in flight is abandoned, and later sensor_done pulses are ignored in IDLE and WAIT_TICK.
- Tick to sensor_start: 1 cycle (tick cycle → START).
- sensor_done to next sensor_start: 2 cycles (ACCUM, then START).
- Final sensor_done to led_valid: 2 cycles (ACCUM, then led_valid registered high in PUSH).
- led_r/g/b update only on entry to PUSH and otherwise hold their last pushed value.
- Minimum burst length is 1 + 3·2^AVG_LOG2 cycles plus sensor latency. A burst longer than PERIOD_CYC causes overrun.

## Structure
- Shared package color_pkg holds:
  - the state enum;
  - RGB_W = 8;
  - the packed rgb_t struct, reusable by the ws2812 and cls381 blocks.
- Single sub-module rgb_accumulator holds:
  - three accumulators;
  - clear, add and shift-average logic;
  - parameter AVG_LOG2.
- FSM, tick counter and timeout counter stay in the top level.
- Target size: ~200 lines RTL.

## Test plan
Bench settings: PERIOD_CYC=200, AVG_LOG2=2, TIMEOUT_CYC=50.
- Nominal burst: four reads (10,20,30), (12,22,32), (14,24,34), (16,26,36) with led_ready=1 → one led_valid pulse with led=(13,23,33); exactly 4 sensor_start pulses per tick.
- Backpressure: led_ready low for 30 cycles → led_valid held, data stable. Handshake on the cycle ready rises, then return to WAIT_TICK.
- Timeout: no sensor_done after the second start → timeout_err=1 at start+50 cycles, no led_valid, normal burst resumes on the next tick.
- Error: sensor_err together with sensor_done → sensor_fail=1, burst discarded, led_r/g/b unchanged.
- Overrun and enable:
  - led_ready held low across a tick → overrun=1.
  - Deassert enable mid-burst → push completes, then IDLE with busy=0 and no further sensor_start.
- Reset: assert sys_rst during WAIT_DATA → next cycle all outputs at reset values, sticky flags cleared.
